// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and width helpers for the shift-and-add
//               multiplier (FSM state encoding, counter and product widths).
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  // Sequencer states of the multiplier
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_SIZE = 32;

  // Iteration counter width: one extra bit so SIZE-1 is always representable
  function automatic int cnt_width(input int size);
    return $clog2(size) + 1;
  endfunction

  // Full product width of a size x size unsigned multiply
  function automatic int prod_width(input int size);
    return 2 * size;
  endfunction

endpackage : mul_pkg
`default_nettype wire

// File: rtl/shift_add_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier_if
// Description : Request/response bundle of the multiplier. The master side
//               issues start with both operands; the slave side returns
//               busy, the done pulse and the held product.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_add_multiplier_if #(
  parameter int SIZE = 32
);

  logic                start;
  logic [SIZE-1:0]     multiplicand;
  logic [SIZE-1:0]     multiplier;
  logic                busy;
  logic                done;
  logic [2*SIZE-1:0]   product;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output product
  );

endinterface : shift_add_multiplier_if
`default_nettype wire

// File: rtl/cl_adder.sv
`default_nettype none
// ============================================================================
// Module      : cl_adder
// Description : SIZE-bit unsigned adder built from per-bit generate and
//               propagate terms; returns the SIZE-bit sum and carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module cl_adder #(
  parameter int SIZE = 32
) (
  input  wire logic [SIZE-1:0] input1_i,
  input  wire logic [SIZE-1:0] input2_i,
  output logic      [SIZE-1:0] result_o,
  output logic                 c_out_o
);

  logic [SIZE-1:0] gen_w;
  logic [SIZE-1:0] prop_w;
  logic [SIZE:0]   carry_w;

  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_bit
      assign gen_w[gi]  = input1_i[gi] & input2_i[gi];
      assign prop_w[gi] = input1_i[gi] ^ input2_i[gi];
    end
  endgenerate

  // Resolve every carry from the generate/propagate terms (carry-in is zero)
  always_comb begin
    carry_w    = '0;
    carry_w[0] = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      carry_w[i+1] = gen_w[i] | (prop_w[i] & carry_w[i]);
    end
  end

  assign result_o = prop_w ^ carry_w[SIZE-1:0];
  assign c_out_o  = carry_w[SIZE];

endmodule : cl_adder
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier
// Description : Multi-cycle unsigned shift-and-add multiplier. One add/shift
//               step per clock through a single cl_adder; SIZE steps per
//               product, followed by a one-cycle done pulse. The product is
//               held in its own register until the next completion.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
  parameter int SIZE = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  shift_add_multiplier_if.slave  bus
);

  import mul_pkg::*;

  localparam int CNT_W  = cnt_width(SIZE);
  localparam int PROD_W = prod_width(SIZE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

  state_t              state_q;
  logic [SIZE-1:0]     m_reg_q;
  logic [PROD_W-1:0]   acc_q;
  logic [PROD_W-1:0]   acc_d;
  logic [PROD_W-1:0]   product_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;

  logic [SIZE-1:0]     hi_w;
  logic [SIZE-1:0]     lo_w;
  logic [SIZE-1:0]     addend_w;
  logic [SIZE-1:0]     sum_w;
  logic                c_out_w;

  assign hi_w = acc_q[PROD_W-1:SIZE];
  assign lo_w = acc_q[SIZE-1:0];

  // Add the multiplicand into the upper half only when the current multiplier bit is set
  always_comb begin
    addend_w = lo_w[0] ? m_reg_q : '0;
  end

  cl_adder #(
    .SIZE (SIZE)
  ) u_cl_adder (
    .input1_i (hi_w),
    .input2_i (addend_w),
    .result_o (sum_w),
    .c_out_o  (c_out_w)
  );

  // Shift the sum (with its carry) down one place; consumed multiplier bit drops out
  always_comb begin
    acc_d = {c_out_w, sum_w, lo_w[SIZE-1:1]};
  end

  // Sequencer with registered busy/done/product; start only matters in IDLE or DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      m_reg_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            m_reg_q <= bus.multiplicand;
            acc_q   <= {{SIZE{1'b0}}, bus.multiplier};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            product_q <= acc_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            m_reg_q <= bus.multiplicand;
            acc_q   <= {{SIZE{1'b0}}, bus.multiplier};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule : shift_add_multiplier
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_multiplier
// Description : Self-checking bench for shift_add_multiplier. A SIZE=32 and a
//               SIZE=4 instance share clock and reset. Expected products are
//               queued when a request is driven and popped on the done pulse.
//               Latency is counted in edges after the accepting edge: done is
//               expected after SIZE further edges (SIZE+1 counting acceptance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  shift_add_multiplier_if #(.SIZE(32)) bus32 ();
  shift_add_multiplier_if #(.SIZE(4))  bus4  ();

  shift_add_multiplier #(.SIZE(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32.slave)
  );

  shift_add_multiplier #(.SIZE(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sb32[$];
  logic [7:0]  sb4[$];

  // Drive a request at a negedge and return right after the accepting posedge
  task automatic launch32(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus32.start        = 1'b1;
    bus32.multiplicand = a;
    bus32.multiplier   = b;
    sb32.push_back(64'(a) * 64'(b));
    @(posedge clk);
  endtask

  // Wait (bounded) for done; edges counted after the accepting edge
  task automatic wait32(input bit hold_start, output int edges, output int busy_cycles,
                        output bit overlap, output bit timed_out);
    edges = 0; busy_cycles = 0; overlap = 1'b0; timed_out = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0 && !hold_start) bus32.start = 1'b0;
      if (bus32.busy) busy_cycles++;
      if (bus32.busy && bus32.done) overlap = 1'b1;
      if (bus32.done) begin
        edges = i;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus32.start = 1'b0; bus32.multiplicand = '0; bus32.multiplier = '0;
    bus4.start  = 1'b0; bus4.multiplicand  = '0; bus4.multiplier  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus32.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy32 got=%b exp=0", bus32.busy); end
    n_checks++; if (bus32.done !== 1'b0) begin n_fail++; $display("FAIL reset_done32 got=%b exp=0", bus32.done); end
    n_checks++; if (bus32.product !== 64'd0) begin n_fail++; $display("FAIL reset_product32 got=%h exp=0", bus32.product); end
    n_checks++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.product !== 8'd0) begin
      n_fail++; $display("FAIL reset_outputs4 got busy=%b done=%b product=%h exp 0/0/0", bus4.busy, bus4.done, bus4.product);
    end
    // start asserted while reset is held must not be taken
    bus32.start = 1'b1;
    @(negedge clk);
    bus32.start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus32.busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored got busy=%b exp=0", bus32.busy); end
  endtask

  task automatic test_products;
    logic [31:0] ta[6];
    logic [31:0] tb_[6];
    logic [63:0] exp;
    int e, bc; bit ov, to;
    ta[0] = 32'd3;          tb_[0] = 32'd5;
    ta[1] = 32'hFFFF_FFFF;  tb_[1] = 32'hFFFF_FFFF;
    ta[2] = 32'h1234_5678;  tb_[2] = 32'd0;
    ta[3] = 32'd0;          tb_[3] = 32'hDEAD_BEEF;
    ta[4] = 32'h8000_0001;  tb_[4] = 32'h8000_0000;
    ta[5] = $urandom;       tb_[5] = $urandom;
    for (int k = 0; k < 6; k++) begin
      launch32(ta[k], tb_[k]);
      wait32(1'b0, e, bc, ov, to);
      exp = sb32.pop_front();
      n_checks++;
      if (to) begin
        n_fail++; $display("FAIL product_timeout op=%0d got no done exp done within 100 cycles", k);
      end else begin
        if (bus32.product !== exp) begin n_fail++; $display("FAIL product op=%0d got=%h exp=%h", k, bus32.product, exp); end
        n_checks++; if (e != 32) begin n_fail++; $display("FAIL latency op=%0d got=%0d exp=32", k, e); end
        n_checks++; if (bc != 32) begin n_fail++; $display("FAIL busy_cycles op=%0d got=%0d exp=32", k, bc); end
        n_checks++; if (ov) begin n_fail++; $display("FAIL busy_done_overlap op=%0d got=1 exp=0", k); end
        repeat (3) @(negedge clk);
        n_checks++; if (bus32.done !== 1'b0 || bus32.product !== exp) begin
          n_fail++; $display("FAIL product_hold op=%0d got done=%b product=%h exp done=0 product=%h", k, bus32.done, bus32.product, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp;
    int e, bc; bit ov, to;
    launch32(32'd2, 32'd4);
    #1;
    bus32.multiplicand = 32'd7;
    bus32.multiplier   = 32'd9;
    wait32(1'b1, e, bc, ov, to);
    exp = sb32.pop_front();
    n_checks++;
    if (to) begin
      n_fail++; $display("FAIL b2b_first_timeout got no done exp done");
    end else begin
      if (bus32.product !== exp) begin n_fail++; $display("FAIL b2b_first_product got=%h exp=%h", bus32.product, exp); end
      n_checks++; if (e != 32) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=32", e); end
      // start is still high in DONE: the 7*9 request is taken at the next edge
      sb32.push_back(64'd7 * 64'd9);
      wait32(1'b0, e, bc, ov, to);
      exp = sb32.pop_front();
      n_checks++;
      if (to) begin
        n_fail++; $display("FAIL b2b_second_timeout got no done exp done");
      end else begin
        if (bus32.product !== exp) begin n_fail++; $display("FAIL b2b_second_product got=%h exp=%h", bus32.product, exp); end
        n_checks++; if (e != 32 || bc != 32) begin n_fail++; $display("FAIL b2b_second_timing got edges=%0d busy=%0d exp 32/32", e, bc); end
      end
    end
    bus32.start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    logic [63:0] exp;
    int e, bc, dones; bit ov, to;
    launch32(32'h0000_ABCD, 32'h0000_1234);
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++; if (bus32.busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy got=%b exp=1", bus32.busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus32.busy !== 1'b0 || bus32.done !== 1'b0 || bus32.product !== 64'd0) begin
      n_fail++; $display("FAIL async_reset got busy=%b done=%b product=%h exp 0/0/0", bus32.busy, bus32.done, bus32.product);
    end
    sb32.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.done) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL discarded_op_done got=%0d pulses exp=0", dones); end
    launch32(32'd100, 32'd200);
    wait32(1'b0, e, bc, ov, to);
    exp = sb32.pop_front();
    n_checks++;
    if (to) begin
      n_fail++; $display("FAIL post_reset_timeout got no done exp done");
    end else if (bus32.product !== exp || exp != 64'd20000) begin
      n_fail++; $display("FAIL post_reset_product got=%h exp=%h", bus32.product, 64'd20000);
    end
  endtask

  task automatic test_exhaustive4;
    logic [7:0] exp;
    int e; bit to;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        bus4.start        = 1'b1;
        bus4.multiplicand = 4'(a);
        bus4.multiplier   = 4'(b);
        sb4.push_back(8'(a * b));
        @(posedge clk);
        to = 1'b1; e = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (i == 0) bus4.start = 1'b0;
          if (bus4.done) begin e = i; to = 1'b0; break; end
        end
        exp = sb4.pop_front();
        n_checks++;
        if (to) begin
          n_fail++; $display("FAIL exh4_timeout a=%0d b=%0d got no done exp done", a, b);
        end else begin
          if (bus4.product !== exp) begin n_fail++; $display("FAIL exh4_product a=%0d b=%0d got=%0d exp=%0d", a, b, bus4.product, exp); end
          n_checks++; if (e != 4) begin n_fail++; $display("FAIL exh4_latency a=%0d b=%0d got=%0d exp=4", a, b, e); end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_products;
    test_back_to_back;
    test_reset_mid_run;
    test_exhaustive4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_shift_add_multiplier
`default_nettype wire
